// File: rtl/tiger_mem_arbiter.sv
// Two-master Avalon-MM arbiter: instruction-cache reads and data-cache reads/writes share one memory port.
// An in-order tag FIFO steers read responses back to their issuer. Define TIGER_ARB_RR_EN for round-robin hand-off.
module tiger_mem_arbiter #(
  parameter int TAG_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ins_read,
  input  logic [31:0] ins_address,
  output logic [31:0] ins_readdata,
  output logic        ins_waitrequest,
  output logic        ins_readdatavalid,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic [31:0] data_readdata,
  output logic        data_waitrequest,
  output logic        data_readdatavalid,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  output logic        arb_error
);
  localparam int PtrW = $clog2(TAG_DEPTH);
  localparam int CntW = PtrW + 1;

  typedef enum logic [1:0] {GrantNone, GrantIns, GrantData} grantT;

  grantT                grantQ, grantNext;
  logic [TAG_DEPTH-1:0] tagMem;
  logic [PtrW-1:0]      wrPtr, rdPtr;
  logic [CntW-1:0]      tagCount;
  logic                 arbErrorQ;

  logic reqIns, reqData, grantedRead, fifoFull, fifoEmpty;
  logic blocked, accepted, push, pop, headOwner;

  assign reqIns      = ins_read;
  assign reqData     = data_read | data_write;
  assign fifoFull    = (tagCount == CntW'(TAG_DEPTH));
  assign fifoEmpty   = (tagCount == '0);
  assign grantedRead = ((grantQ == GrantIns) & ins_read) | ((grantQ == GrantData) & data_read);
  assign blocked     = grantedRead & fifoFull;
  assign accepted    = (mem_read | mem_write) & ~mem_waitrequest;
  assign push        = accepted & mem_read;
  assign pop         = mem_readdatavalid & ~fifoEmpty;
  assign headOwner   = tagMem[rdPtr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) grantQ <= GrantNone;
    else          grantQ <= grantNext;
  end

  // NOTE: tag storage is not reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) tagMem[wrPtr] <= (grantQ == GrantData);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      tagCount  <= '0;
      arbErrorQ <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   tagCount <= tagCount + 1'b1;
        2'b01:   tagCount <= tagCount - 1'b1;
        default: ;
      endcase
      if (mem_readdatavalid && fifoEmpty) arbErrorQ <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    grantNext = grantQ;
    case (grantQ)
      GrantNone: begin
        if (reqData)     grantNext = GrantData;
        else if (reqIns) grantNext = GrantIns;
      end
      GrantIns: begin
        if (!reqIns)       grantNext = reqData ? GrantData : GrantNone;
        else if (accepted && reqData) grantNext = GrantData;
      end
      GrantData: begin
        if (!reqData)      grantNext = reqIns ? GrantIns : GrantNone;
`ifdef TIGER_ARB_RR_EN
        else if (accepted && reqIns) grantNext = GrantIns;
`else
        else               grantNext = GrantData;
`endif
      end
      default: grantNext = GrantNone;
    endcase
  end

  always_comb begin
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    mem_address      = '0;
    mem_writedata    = '0;
    mem_byteenable   = '0;
    ins_waitrequest  = 1'b1;
    data_waitrequest = 1'b1;
    case (grantQ)
      GrantIns: begin
        mem_read        = ins_read & ~fifoFull;
        mem_address     = ins_address;
        mem_byteenable  = 4'hF;
        ins_waitrequest = mem_waitrequest | blocked;
      end
      GrantData: begin
        mem_read         = data_read & ~fifoFull;
        mem_write        = data_write;
        mem_address      = data_address;
        mem_writedata    = data_writedata;
        mem_byteenable   = data_byteenable;
        data_waitrequest = mem_waitrequest | blocked;
      end
      default: ;
    endcase
  end

  assign ins_readdata       = mem_readdata;
  assign data_readdata      = mem_readdata;
  assign ins_readdatavalid  = pop & ~headOwner;
  assign data_readdatavalid = pop & headOwner;
  assign arb_error          = arbErrorQ;
endmodule

// File: tb/tb_tiger_mem_arbiter.sv
// Directed bench for tiger_mem_arbiter (fixed-priority build, TAG_DEPTH = 8).
// Inputs change 1 ns after the rising edge; outputs are compared mid-cycle.
module tb_tiger_mem_arbiter;
  logic        clk;
  logic        reset_n;
  logic        ins_read;
  logic [31:0] ins_address;
  logic [31:0] ins_readdata;
  logic        ins_waitrequest;
  logic        ins_readdatavalid;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic        data_waitrequest;
  logic        data_readdatavalid;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        mem_readdatavalid;
  logic        arb_error;

  int nChecks = 0;
  int nPass   = 0;

  tiger_mem_arbiter #(.TAG_DEPTH(8)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .ins_read           (ins_read),
    .ins_address        (ins_address),
    .ins_readdata       (ins_readdata),
    .ins_waitrequest    (ins_waitrequest),
    .ins_readdatavalid  (ins_readdatavalid),
    .data_read          (data_read),
    .data_write         (data_write),
    .data_address       (data_address),
    .data_writedata     (data_writedata),
    .data_byteenable    (data_byteenable),
    .data_readdata      (data_readdata),
    .data_waitrequest   (data_waitrequest),
    .data_readdatavalid (data_readdatavalid),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_address        (mem_address),
    .mem_writedata      (mem_writedata),
    .mem_byteenable     (mem_byteenable),
    .mem_readdata       (mem_readdata),
    .mem_waitrequest    (mem_waitrequest),
    .mem_readdatavalid  (mem_readdatavalid),
    .arb_error          (arb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    reset_n = 1'b0;  ins_read = 1'b0;  ins_address = '0;
    data_read = 1'b0; data_write = 1'b0; data_address = '0;
    data_writedata = '0; data_byteenable = '0;
    mem_readdata = '0; mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0;

    // Reset held for two edges, all requests idle
    cyc(); cyc();
    #3;
    check("rst_mem_read",  mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_ins_wait",  ins_waitrequest, 1);
    check("rst_data_wait", data_waitrequest, 1);
    check("rst_arb_error", arb_error, 0);
    check("rst_ins_rdv",   ins_readdatavalid, 0);
    check("rst_data_rdv",  data_readdatavalid, 0);

    // Single instruction read of 0x100, response three cycles later
    cyc();
    reset_n = 1'b1; ins_read = 1'b1; ins_address = 32'h100;
    #3;
    check("ins1_latency_read", mem_read, 0);
    check("ins1_latency_wait", ins_waitrequest, 1);
    cyc();
    #3;
    check("ins1_mem_read", mem_read, 1);
    check("ins1_mem_addr", mem_address, 32'h100);
    check("ins1_mem_be",   mem_byteenable, 4'hF);
    check("ins1_mem_wr",   mem_write, 0);
    check("ins1_ins_wait", ins_waitrequest, 0);
    cyc();
    ins_read = 1'b0;
    #3;
    check("ins1_idle_read", mem_read, 0);
    cyc(); cyc();
    mem_readdatavalid = 1'b1; mem_readdata = 32'hDEADBEEF;
    #3;
    check("ins1_rdv",       ins_readdatavalid, 1);
    check("ins1_rdata",     ins_readdata, 32'hDEADBEEF);
    check("ins1_data_rdv",  data_readdatavalid, 0);
    cyc();
    mem_readdatavalid = 1'b0;
    #3;
    check("ins1_rdv_clear", ins_readdatavalid, 0);
    check("ins1_no_error",  arb_error, 0);

    // Simultaneous instruction read and data write: data first, one bubble, then instruction
    cyc();
    ins_read = 1'b1; ins_address = 32'h300;
    data_write = 1'b1; data_address = 32'h200; data_writedata = 32'h12345678; data_byteenable = 4'h3;
    #3;
    check("pri_arb_write", mem_write, 0);
    cyc();
    #3;
    check("pri_mem_write", mem_write, 1);
    check("pri_mem_read",  mem_read, 0);
    check("pri_mem_addr",  mem_address, 32'h200);
    check("pri_mem_wdata", mem_writedata, 32'h12345678);
    check("pri_mem_be",    mem_byteenable, 4'h3);
    check("pri_data_wait", data_waitrequest, 0);
    check("pri_ins_wait",  ins_waitrequest, 1);
    cyc();
    data_write = 1'b0;
    #3;
    check("pri_bubble_rd", mem_read, 0);
    check("pri_bubble_wr", mem_write, 0);
    cyc();
    #3;
    check("pri_ins_read", mem_read, 1);
    check("pri_ins_addr", mem_address, 32'h300);
    check("pri_ins_wait_lo", ins_waitrequest, 0);
    cyc();
    ins_read = 1'b0;
    mem_readdatavalid = 1'b1; mem_readdata = 32'hCAFE0001;
    #3;
    check("pri_ins_rdv", ins_readdatavalid, 1);
    cyc();
    mem_readdatavalid = 1'b0;

    // Tag FIFO full: nine instruction reads, no responses
    ins_read = 1'b1; ins_address = 32'h1000;
    cyc();
    for (int k = 0; k < 8; k++) begin
      ins_address = 32'h1000 + 32'(k * 4);
      #3;
      check("full_fill_read", mem_read, 1);
      check("full_fill_addr", mem_address, 32'h1000 + 32'(k * 4));
      cyc();
    end
    ins_address = 32'h1020;
    #3;
    check("full_ninth_wait", ins_waitrequest, 1);
    check("full_ninth_read", mem_read, 0);
    cyc();
    mem_readdatavalid = 1'b1; mem_readdata = 32'h0000F001;
    #3;
    check("full_resp_rdv",  ins_readdatavalid, 1);
    check("full_prepop_wait", ins_waitrequest, 1);
    check("full_prepop_read", mem_read, 0);
    cyc();
    mem_readdatavalid = 1'b0;
    #3;
    check("full_ninth_issue", mem_read, 1);
    check("full_ninth_addr",  mem_address, 32'h1020);
    check("full_ninth_go",    ins_waitrequest, 0);
    cyc();
    ins_read = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mem_readdatavalid = 1'b1; mem_readdata = 32'h0000F100 + 32'(k);
      #3;
      check("drain_ins_rdv",  ins_readdatavalid, 1);
      check("drain_data_rdv", data_readdatavalid, 0);
      cyc();
    end
    mem_readdatavalid = 1'b0;
    #3;
    check("drain_no_error", arb_error, 0);

    // Interleaved INS, DATA, INS reads; first INS read stalled once by memory
    cyc();
    ins_read = 1'b1; ins_address = 32'h2000; mem_waitrequest = 1'b1;
    cyc();
    #3;
    check("il_stall_read", mem_read, 1);
    check("il_stall_wait", ins_waitrequest, 1);
    cyc();
    mem_waitrequest = 1'b0;
    #3;
    check("il_ins_go",   ins_waitrequest, 0);
    check("il_ins_addr", mem_address, 32'h2000);
    cyc();
    ins_read = 1'b0;
    data_read = 1'b1; data_address = 32'h3000; data_byteenable = 4'hC;
    #3;
    check("il_switch_bubble", mem_read, 0);
    cyc();
    #3;
    check("il_data_read", mem_read, 1);
    check("il_data_addr", mem_address, 32'h3000);
    check("il_data_be",   mem_byteenable, 4'hC);
    check("il_data_wait", data_waitrequest, 0);
    check("il_ins_blocked", ins_waitrequest, 1);
    cyc();
    data_read = 1'b0;
    ins_read = 1'b1; ins_address = 32'h2004;
    cyc();
    #3;
    check("il_ins2_read", mem_read, 1);
    check("il_ins2_addr", mem_address, 32'h2004);
    cyc();
    ins_read = 1'b0;
    mem_readdatavalid = 1'b1; mem_readdata = 32'hAAAA0001;
    #3;
    check("il_a_ins_rdv",  ins_readdatavalid, 1);
    check("il_a_data_rdv", data_readdatavalid, 0);
    check("il_a_rdata",    ins_readdata, 32'hAAAA0001);
    cyc();
    mem_readdata = 32'hBBBB0002;
    #3;
    check("il_b_ins_rdv",  ins_readdatavalid, 0);
    check("il_b_data_rdv", data_readdatavalid, 1);
    check("il_b_rdata",    data_readdata, 32'hBBBB0002);
    cyc();
    mem_readdata = 32'hCCCC0003;
    #3;
    check("il_c_ins_rdv",  ins_readdatavalid, 1);
    check("il_c_data_rdv", data_readdatavalid, 0);
    cyc();
    mem_readdatavalid = 1'b0;
    #3;
    check("il_no_error", arb_error, 0);

    // Stray response with nothing outstanding
    cyc();
    mem_readdatavalid = 1'b1; mem_readdata = 32'h0BAD0BAD;
    #3;
    check("err_ins_rdv",  ins_readdatavalid, 0);
    check("err_data_rdv", data_readdatavalid, 0);
    cyc();
    mem_readdatavalid = 1'b0;
    #3;
    check("err_set", arb_error, 1);
    cyc(); cyc();
    #3;
    check("err_sticky", arb_error, 1);
    cyc();
    reset_n = 1'b0;
    cyc();
    #3;
    check("err_cleared", arb_error, 0);
    check("err_rst_wait", ins_waitrequest, 1);
    reset_n = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/tiger_mem_arbiter.md
# tiger_mem_arbiter

Two-master Avalon-MM arbiter sitting directly downstream of the Tiger core's instruction and data caches. It merges the instruction-cache read master and the data-cache read/write master onto one external memory master port. It tracks outstanding pipelined reads in an in-order tag FIFO and steers each returning `readdatavalid` back to the cache that issued the read.

## Interface
Parameters:
- `TAG_DEPTH`, 8: maximum outstanding reads accepted by memory; power of two, 2..64.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `ins_read` in 1: instruction master read request.
- `ins_address` in 32: instruction read address.
- `ins_readdata` out 32: read data, shared with the data master.
- `ins_waitrequest` out 1: instruction command not accepted this cycle.
- `ins_readdatavalid` out 1: `ins_readdata` is valid for an instruction read.
- `data_read`, `data_write` in 1 each: data master requests; never both high.
- `data_address` in 32; `data_writedata` in 32; `data_byteenable` in 4.
- `data_readdata` out 32; `data_waitrequest` out 1; `data_readdatavalid` out 1.
- `mem_read`, `mem_write` out 1 each; `mem_address` out 32; `mem_writedata` out 32; `mem_byteenable` out 4.
- `mem_readdata` in 32; `mem_waitrequest` in 1; `mem_readdatavalid` in 1.
- `arb_error` out 1: sticky; set when `mem_readdatavalid` arrives with the tag FIFO empty.

## Operation
- Grant register: NONE / INS / DATA. Requests: `r_i = ins_read`, `r_d = data_read | data_write`.
- Command path is combinational from the grant register:
  - The granted master's command, address, writedata and byteenable drive `mem_*`. Instruction commands drive byteenable 4'hF and `mem_write` = 0.
  - The granted master's `waitrequest` equals `mem_waitrequest | blocked`.
  - The non-granted master sees `waitrequest` = 1.
  - With grant NONE, `mem_read`, `mem_write` = 0 and both waitrequests = 1.
- `blocked` = granted command is a read and the tag FIFO is full. While blocked, `mem_read` is forced to 0. Writes are never blocked.
- Accepted = `(mem_read | mem_write) & !mem_waitrequest`. An accepted read pushes the owner bit (0 = INS, 1 = DATA) into the tag FIFO.
- On `mem_readdatavalid`, pop the FIFO head and assert the matching `*_readdatavalid` in the same cycle. `mem_readdata` is broadcast to both `*_readdata` unmodified.
- A push and a pop in the same cycle leave the count unchanged. This is legal even when the FIFO is full, but the full flag used for `blocked` is the pre-edge flag.
- `mem_readdatavalid` with the FIFO empty: no valid is forwarded, `arb_error` is set, and the count stays 0.
- Grant update, evaluated each edge:
  - NONE: go to DATA if `r_d`, else INS if `r_i`, else stay NONE.
  - Owner requesting and not accepted (including blocked): hold.
  - Owner idle (no request): switch to the other master if it is requesting, else go to NONE.
  - Owner accepted: fixed-priority rule, or round-robin when `TIGER_ARB_RR_EN` is defined (see Configuration).
    - INS: go to DATA if `r_d`, else hold.
    - DATA: hold, since DATA keeps the grant while requesting.
- Read responses return strictly in memory order. Interleaved INS and DATA reads are legal.

## Timing
- Reset (`reset_n` = 0 at an edge) clears:
  - grant to NONE;
  - FIFO pointers and count to 0;
  - `arb_error` to 0.
- After reset: `mem_read`, `mem_write` = 0, both waitrequests = 1, both readdatavalids = 0.
- Reset mid-transaction discards outstanding tags. Responses arriving afterwards set `arb_error`.
- Arbitration latency: one cycle from a request with grant NONE to the command appearing on `mem_*`.
- Switching between masters costs one bubble cycle. Back-to-back commands from the same owner incur no bubble.
- Response path has zero added latency: `*_readdatavalid` is combinational from `mem_readdatavalid` and the FIFO head.
- FIFO count width is log2(TAG_DEPTH)+1. Pointers wrap modulo TAG_DEPTH.

## Configuration
- `TIGER_ARB_RR_EN` defined: round-robin. After an accepted command, the grant passes to the other master if it is requesting; either owner yields.
- Undefined: fixed priority, with data above instruction. DATA keeps the grant until `r_d` drops. INS yields to a pending `r_d` after each accepted command.

## Test plan
- Reset then idle: hold `reset_n` = 0 for 2 cycles, all requests low → `mem_read` = `mem_write` = 0, both waitrequests = 1, `arb_error` = 0.
- Single INS read of 0x100, memory returns 0xDEADBEEF after 3 cycles → command on `mem_*` 1 cycle after request; `ins_readdatavalid` = 1 with 0xDEADBEEF; `data_readdatavalid` stays 0.
- Simultaneous `ins_read` and `data_write` (0x200, 0x12345678, be 4'h3), fixed priority → data write issued first with be 4'h3. The INS read follows after one bubble.
- TAG_DEPTH = 8, INS issues 9 reads with no responses → the 9th sees `ins_waitrequest` = 1 and `mem_read` = 0. One response lets the 9th read issue the next cycle.
- Interleave INS, DATA, INS reads, with responses A, B, C returned in order → valids route to INS, DATA, INS respectively.
- Inject `mem_readdatavalid` with no outstanding reads → no readdatavalid forwarded; `arb_error` = 1 and stays 1 until reset.
